i2s_tx_serializer: RTL and testbench
====================================

# i2s_tx_serializer

Serializes stereo PCM samples into an I2S bit stream for the Zedboard audio codec. It sits directly downstream of the AXI4-Lite `i2s_data` register block, which supplies left/right samples through a valid/ready handshake. The block generates BCLK, LRCLK and SDATA from the AXI clock. An optional capture path deserializes codec ADC data back to the register block.

## Interface
- `DATA_WIDTH`, 24: sample width in bits; must be ≤ `SLOT_WIDTH`-1.
- `SLOT_WIDTH`, 32: BCLK periods per channel slot.
- `BCLK_DIV`, 16: ACLK cycles per BCLK half-period; must be ≥ 2.

- `ACLK`  in  1  system clock; all logic is on the rising edge.
- `ARESETN`  in  1  synchronous, active-low reset.
- `enable`  in  1  high runs the serializer; low holds the reset state except the holding register.
- `s_left`  in  DATA_WIDTH  left sample.
- `s_right`  in  DATA_WIDTH  right sample.
- `s_valid`  in  1  sample pair valid.
- `s_ready`  out  1  holding register empty.
- `bclk`  out  1  bit clock to codec.
- `lrclk`  out  1  word select; 0 = left, 1 = right.
- `sdata_out`  out  1  DAC serial data.
- `frame_start`  out  1  one-cycle pulse when a frame begins.
- `underrun`  out  1  one-cycle pulse when a frame begins with no sample available.
- `sdata_in`  in  1  ADC serial data (`I2S_RX_EN` only).
- `m_left`, `m_right`  out  DATA_WIDTH  captured samples (`I2S_RX_EN` only).
- `m_valid`  out  1  one-cycle pulse when new captured samples are available (`I2S_RX_EN` only).

## Operation
- **Buffering:**
  - Two stages: holding register (`hold`, flag `hold_full`) and frame register (`frame`).
  - A handshake (`s_valid && s_ready`) loads `hold` and sets `hold_full`.
  - `s_ready` = !`hold_full`, registered.
- **Counters:**
  - `div_cnt` runs 0..BCLK_DIV-1. At BCLK_DIV-1 it wraps and `bclk` toggles.
  - A "fall event" is a toggle while `bclk`=1; a "rise event" is a toggle while `bclk`=0.
  - `bit_cnt` runs 0..2*SLOT_WIDTH-1 and advances on each fall event.
- **Fall event**, with next value n = (`bit_cnt`+1) mod 2*SLOT_WIDTH and slot position p = n mod SLOT_WIDTH:
  - `lrclk` ← (n ≥ SLOT_WIDTH).
  - `sdata_out` ← `frame` channel bit [DATA_WIDTH-p] for 1 ≤ p ≤ DATA_WIDTH; 0 otherwise (one-BCLK I2S delay, MSB first, zero-padded).
- **Frame load:** on a fall event with n = 0:
  - If `hold_full`: `frame` ← `hold`, `hold_full` cleared.
  - Otherwise: `frame` ← 0 and `underrun` pulses.
  - `frame_start` pulses in either case.
- **Simultaneous handshake and frame load:** the load sees the pre-handshake `hold_full`. If it was 0, the frame underruns and the new data stays in `hold` for the next frame.
- **Enable:**
  - `enable` low forces `div_cnt`=0, `bit_cnt`=2*SLOT_WIDTH-1, and `bclk`/`lrclk`/`sdata_out`=0 on the next edge.
  - `hold` and `hold_full` are preserved; `s_ready` stays functional.
  - Dropping `enable` mid-frame aborts the frame immediately; `frame` is discarded.
- **Reset values:**
  - `bclk`, `lrclk`, `sdata_out`, `frame_start`, `underrun`, `m_valid` = 0.
  - `s_ready` = 1.
  - `m_left`, `m_right` = 0; `hold_full` = 0; counters as in the disabled state.

## Timing
- First rise event occurs BCLK_DIV cycles after `enable` is sampled high.
- First fall event (frame start, `frame_start` pulse) occurs 2*BCLK_DIV cycles after `enable` is sampled high.
- Outputs change only on fall events, so the codec samples them on BCLK rising edges.
- Frame length is 2*SLOT_WIDTH*2*BCLK_DIV ACLK cycles.
- `s_ready` falls the cycle after a handshake and rises the cycle after the frame load that empties `hold`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `I2S_RX_EN` defined:
  - `sdata_in` is sampled on each rise event into a shift register.
  - Bit at slot position p (1..DATA_WIDTH) goes to channel bit [DATA_WIDTH-p].
  - On each frame-load fall event except the first after enable, `m_left`/`m_right` update and `m_valid` pulses in the same cycle as `frame_start`.
  - No backpressure.
- `I2S_RX_EN` undefined: `sdata_in`, `m_left`, `m_right` and `m_valid` ports and the capture logic are absent.

## Test plan
All scenarios use DATA_WIDTH=24, SLOT_WIDTH=32, BCLK_DIV=2.
1. Hold `ARESETN`=0 for 10 cycles with `enable`=1 → all outputs at reset values, `s_ready`=1; `bclk` first rises 2 cycles after release.
2. Preload L=0xA5A5A5, R=0x5A5A5A, then enable → on `sdata_out`:
   - Left slot: 0, 24 bits 101001011010010110100101, 7 zeros.
   - Right slot: 0, 24 bits 010110100101101001011010, 7 zeros.
   - `lrclk` low for 32 BCLKs, then high for 32; `underrun` never pulses.
3. Enable with no data → every `frame_start` accompanied by an `underrun` pulse; `sdata_out` stays 0.
4. `s_valid` held high across frames with 3 distinct pairs:
   - After each handshake, `s_ready` is low until the next frame load.
   - Pairs appear in order on consecutive frames with no underrun after the first frame.
5. Drop `enable` at `bit_cnt`=40 → outputs 0 the next cycle.
   - A pending `hold` survives.
   - On re-enable, that pair transmits in the first frame.
6. With `I2S_RX_EN`, loop `sdata_out` to `sdata_in` and send L=0x123456, R=0xABCDEF:
   - `m_left`=0x123456 and `m_right`=0xABCDEF with `m_valid` at the following `frame_start`.
   - No `m_valid` at the first frame start after enable.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: two-stage sample buffer, BCLK/LRCLK generation and MSB-first serialization.
// Optional capture path for codec ADC data is enabled by defining I2S_RX_EN.
module i2s_tx_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata_out,
    output logic                  frame_start,
    output logic                  underrun
`ifdef I2S_RX_EN
    ,
    input  logic                  sdata_in,
    output logic [DATA_WIDTH-1:0] m_left,
    output logic [DATA_WIDTH-1:0] m_right,
    output logic                  m_valid
`endif
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int DIVW       = $clog2(BCLK_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0]   SLOT_W   = BW'(SLOT_WIDTH);

    logic [DIVW-1:0]       div_cnt_reg;
    logic [BW-1:0]         bit_cnt_reg;
    logic                  bclk_reg;
    logic                  lrclk_reg;
    logic                  sdata_reg;
    logic                  frame_start_reg;
    logic                  underrun_reg;
    logic [DATA_WIDTH-1:0] hold_left_reg;
    logic [DATA_WIDTH-1:0] hold_right_reg;
    logic                  hold_full_reg;
    logic [DATA_WIDTH-1:0] frame_left_reg;
    logic [DATA_WIDTH-1:0] frame_right_reg;

    logic                  tick;
    logic                  fall_evt;
    logic                  load_evt;
    logic                  handshake;
    logic [BW-1:0]         bit_next;
    logic [BW-1:0]         tx_pos;
    logic [DATA_WIDTH-1:0] tx_word;
    logic                  tx_bit;

    function automatic logic [BW-1:0] slot_pos(input logic [BW-1:0] b);
        return (b >= SLOT_W) ? b - SLOT_W : b;
    endfunction

    assign tick      = (div_cnt_reg == DIV_LAST);
    assign fall_evt  = enable && tick && bclk_reg;
    assign bit_next  = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
    assign load_evt  = fall_evt && (bit_next == '0);
    assign handshake = s_valid && !hold_full_reg;

    // Position 0 of each slot is the one-BCLK delay bit; positions past DATA_WIDTH are padding.
    always_comb begin
        tx_word = (bit_next >= SLOT_W) ? frame_right_reg : frame_left_reg;
        tx_pos  = slot_pos(bit_next);
        tx_bit  = 1'b0;
        for (int i = 1; i <= DATA_WIDTH; i++) begin
            if (int'(tx_pos) == i) begin
                tx_bit = tx_word[DATA_WIDTH-i];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            div_cnt_reg     <= '0;
            bit_cnt_reg     <= BIT_LAST;
            bclk_reg        <= 1'b0;
            lrclk_reg       <= 1'b0;
            sdata_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
            hold_left_reg   <= '0;
            hold_right_reg  <= '0;
            hold_full_reg   <= 1'b0;
            frame_left_reg  <= '0;
            frame_right_reg <= '0;
        end else begin
            // The holding register keeps working while disabled.
            if (handshake) begin
                hold_left_reg  <= s_left;
                hold_right_reg <= s_right;
                hold_full_reg  <= 1'b1;
            end else if (load_evt && hold_full_reg) begin
                hold_full_reg  <= 1'b0;
            end

            if (!enable) begin
                div_cnt_reg     <= '0;
                bit_cnt_reg     <= BIT_LAST;
                bclk_reg        <= 1'b0;
                lrclk_reg       <= 1'b0;
                sdata_reg       <= 1'b0;
                frame_start_reg <= 1'b0;
                underrun_reg    <= 1'b0;
                frame_left_reg  <= '0;
                frame_right_reg <= '0;
            end else begin
                div_cnt_reg     <= tick ? '0 : div_cnt_reg + 1'b1;
                frame_start_reg <= load_evt;
                underrun_reg    <= load_evt && !hold_full_reg;
                if (tick) begin
                    bclk_reg <= !bclk_reg;
                end
                if (fall_evt) begin
                    bit_cnt_reg <= bit_next;
                    lrclk_reg   <= (bit_next >= SLOT_W);
                    sdata_reg   <= tx_bit;
                end
                if (load_evt) begin
                    frame_left_reg  <= hold_full_reg ? hold_left_reg : '0;
                    frame_right_reg <= hold_full_reg ? hold_right_reg : '0;
                end
            end
        end
    end

    assign s_ready     = !hold_full_reg;
    assign bclk        = bclk_reg;
    assign lrclk       = lrclk_reg;
    assign sdata_out   = sdata_reg;
    assign frame_start = frame_start_reg;
    assign underrun    = underrun_reg;

`ifdef I2S_RX_EN
    logic                  rise_evt;
    logic                  rx_is_right;
    logic [BW-1:0]         rx_pos;
    logic [DATA_WIDTH-1:0] rx_hit;
    logic [DATA_WIDTH-1:0] rx_left_reg;
    logic [DATA_WIDTH-1:0] rx_right_reg;
    logic [DATA_WIDTH-1:0] rx_left_next;
    logic [DATA_WIDTH-1:0] rx_right_next;
    logic [DATA_WIDTH-1:0] m_left_reg;
    logic [DATA_WIDTH-1:0] m_right_reg;
    logic                  m_valid_reg;
    logic                  rx_primed_reg;

    // On a rise event bit_cnt still names the bit currently driven on the wire.
    assign rise_evt    = enable && tick && !bclk_reg;
    assign rx_is_right = (bit_cnt_reg >= SLOT_W);
    assign rx_pos      = slot_pos(bit_cnt_reg);

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rx_bit
        assign rx_hit[gi]        = rise_evt && (int'(rx_pos) == DATA_WIDTH - gi);
        assign rx_left_next[gi]  = (rx_hit[gi] && !rx_is_right) ? sdata_in : rx_left_reg[gi];
        assign rx_right_next[gi] = (rx_hit[gi] && rx_is_right) ? sdata_in : rx_right_reg[gi];
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rx_left_reg   <= '0;
            rx_right_reg  <= '0;
            m_left_reg    <= '0;
            m_right_reg   <= '0;
            m_valid_reg   <= 1'b0;
            rx_primed_reg <= 1'b0;
        end else if (!enable) begin
            m_valid_reg   <= 1'b0;
            rx_primed_reg <= 1'b0;
        end else begin
            rx_left_reg  <= rx_left_next;
            rx_right_reg <= rx_right_next;
            // The first frame after enable has no complete capture behind it.
            m_valid_reg  <= load_evt && rx_primed_reg;
            if (load_evt) begin
                rx_primed_reg <= 1'b1;
                if (rx_primed_reg) begin
                    m_left_reg  <= rx_left_reg;
                    m_right_reg <= rx_right_reg;
                end
            end
        end
    end

    assign m_left  = m_left_reg;
    assign m_right = m_right_reg;
    assign m_valid = m_valid_reg;
`endif

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: directed vectors, hand-written corner sequences and a frame-level
// scoreboard fed by randomized traffic. Define I2S_RX_EN to include the loopback capture checks.
module tb_i2s_tx_serializer;
    localparam int DW        = 24;
    localparam int SW        = 32;
    localparam int DIV       = 2;
    localparam int FB        = 2 * SW;
    localparam int FRAME_CYC = FB * 2 * DIV;

    logic          clk = 1'b0;
    logic          ARESETN;
    logic          enable;
    logic [DW-1:0] s_left;
    logic [DW-1:0] s_right;
    logic          s_valid;
    logic          s_ready;
    logic          bclk;
    logic          lrclk;
    logic          sdata_out;
    logic          frame_start;
    logic          underrun;
`ifdef I2S_RX_EN
    logic          sdata_in;
    logic [DW-1:0] m_left;
    logic [DW-1:0] m_right;
    logic          m_valid;
    assign sdata_in = sdata_out;
`endif

    always #5 clk = ~clk;

    i2s_tx_serializer #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_DIV(DIV)) dut (
        .ACLK(clk), .ARESETN(ARESETN), .enable(enable),
        .s_left(s_left), .s_right(s_right), .s_valid(s_valid), .s_ready(s_ready),
        .bclk(bclk), .lrclk(lrclk), .sdata_out(sdata_out),
        .frame_start(frame_start), .underrun(underrun)
`ifdef I2S_RX_EN
        , .sdata_in(sdata_in), .m_left(m_left), .m_right(m_right), .m_valid(m_valid)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected slot contents, MSB first: delay bit, sample bits, zero padding.
    function automatic logic [SW-1:0] slot_word(input logic [DW-1:0] x);
        logic [SW-1:0] w;
        w = '0;
        for (int p = 1; p <= DW; p++) w[SW-1-p] = x[DW-p];
        return w;
    endfunction

    // ---------------- frame-level scoreboard ----------------
    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            edge_no;
    } pend_t;
    pend_t pend[$];

    initial begin : monitor
        int          neg_no;
        int          last_fs;
        int          bitpos;
        int          frame_no;
        bit          active;
        logic        bclk_q, en_q, rst_q, rdy_q, exp_ur;
        logic [DW-1:0] cur_l, cur_r;
        logic [63:0] got_sd, got_lr;
        pend_t       pe;
        neg_no = 0; last_fs = 0; bitpos = 0; frame_no = 0; active = 0;
        bclk_q = 0; en_q = 0; rst_q = 0; rdy_q = 1; cur_l = '0; cur_r = '0;
        got_sd = '0; got_lr = '0;
        forever begin
            @(negedge clk);
            neg_no++;
            if (rst_q && en_q) begin
                if (frame_start) begin
                    if (active)
                        check("frame_period", {32'(bitpos), 32'(neg_no - last_fs)}, {32'(FB), 32'(FRAME_CYC)});
                    exp_ur = !(pend.size() > 0 && pend[0].edge_no < neg_no);
                    check("underrun_at_frame_start", 64'(underrun), 64'(exp_ur));
                    if (!exp_ur) begin
                        pe = pend.pop_front();
                        cur_l = pe.l; cur_r = pe.r;
                    end else begin
                        cur_l = '0; cur_r = '0;
                    end
                    active = 1; bitpos = 0; last_fs = neg_no; frame_no++;
                    got_sd = '0; got_lr = '0;
                end else if (underrun) begin
                    check("underrun_without_frame_start", 64'(frame_start), 64'(1));
                end
                if (active && bclk_q && !bclk) begin
                    if (bitpos < FB) begin
                        got_sd[FB-1-bitpos] = sdata_out;
                        got_lr[FB-1-bitpos] = lrclk;
                    end
                    bitpos++;
                    if (bitpos == FB) begin
                        $display("[TB] frame %0d L=%06h R=%06h sdata=%016h", frame_no, cur_l, cur_r, got_sd);
                        check($sformatf("frame%0d_sdata", frame_no), got_sd, {slot_word(cur_l), slot_word(cur_r)});
                        check($sformatf("frame%0d_lrclk", frame_no), got_lr, 64'h0000_0000_FFFF_FFFF);
                    end
                end
                if (!rdy_q && s_ready)
                    check("s_ready_rises_at_frame_load", 64'(frame_start), 64'(1));
            end else begin
                active = 0;
            end
            if (ARESETN && s_valid && s_ready)
                pend.push_back('{s_left, s_right, neg_no + 1});
            bclk_q = bclk; en_q = enable; rst_q = ARESETN; rdy_q = s_ready;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int n;
        n = 0;
        while (!s_ready && n < 5000) begin step(1); n++; end
        if (!s_ready) begin
            check("s_ready_wait", 64'(s_ready), 64'(1));
            return;
        end
        s_left = l; s_right = r; s_valid = 1'b1;
        step(1);
        s_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_start && n < 2000) begin @(negedge clk); n++; end
        if (!frame_start) check("frame_start_timeout", 64'(frame_start), 64'(1));
    endtask

    task automatic capture_frame(output logic [63:0] sd, output logic [63:0] lr, output logic ur);
        int   n, cnt;
        logic prev;
        sd = '0; lr = '0; ur = 1'b0;
        wait_fs();
        if (frame_start) begin
            ur = underrun; sd[63] = sdata_out; lr[63] = lrclk;
            prev = bclk; cnt = 1; n = 0;
            while (cnt < FB && n < 4000) begin
                @(negedge clk); n++;
                if (prev && !bclk) begin
                    sd[63-cnt] = sdata_out; lr[63-cnt] = lrclk; cnt++;
                end
                prev = bclk;
            end
            if (cnt < FB) check("capture_bits", 64'(cnt), 64'(FB));
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [SW-1:0] exp_ls;
        logic [SW-1:0] exp_rs;
    } vec_t;

    initial begin : main
        vec_t          vecs[4];
        logic [DW-1:0] p4_l[3];
        logic [DW-1:0] p4_r[3];
        logic [63:0]   sd, lr;
        logic          ur, rdy;
        int            cnt, fs_cnt, ur_cnt, hi_cnt, idx, n;

        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 32'h52D2_D280, 32'h2D2D_2D00};
        vecs[1] = '{24'h123456, 24'hABCDEF, 32'h091A_2B00, 32'h55E6_F780};
        vecs[2] = '{24'hFFFFFF, 24'h000001, 32'h7FFF_FF80, 32'h0000_0080};
        vecs[3] = '{24'h800000, 24'h000000, 32'h4000_0000, 32'h0000_0000};
        p4_l = '{24'h111111, 24'h222222, 24'h333333};
        p4_r = '{24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC};

        // Reset with enable high
        ARESETN = 1'b0; enable = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({bclk, lrclk, sdata_out, frame_start, underrun, s_ready}), 64'(6'b000001));
`ifdef I2S_RX_EN
        check("reset_capture", 64'({m_valid, m_left, m_right}), 64'(0));
`endif
        @(posedge clk); #1;
        ARESETN = 1'b1;
        cnt = 0;
        do begin step(1); cnt++; end while (!bclk && cnt < 20);
        $display("[TB] reset released, bclk rose after %0d cycles", cnt);
        check("first_bclk_rise_latency", 64'(cnt), 64'(DIV));

        // No data: every frame underruns and the line stays low
        fs_cnt = 0; ur_cnt = 0; hi_cnt = 0;
        repeat (3 * FRAME_CYC) begin
            @(negedge clk);
            fs_cnt += int'(frame_start); ur_cnt += int'(underrun); hi_cnt += int'(sdata_out);
        end
        $display("[TB] idle window: %0d frame starts, %0d underruns, %0d high bits", fs_cnt, ur_cnt, hi_cnt);
        check("idle_frame_starts", 64'(fs_cnt), 64'(3));
        check("idle_underruns", 64'(ur_cnt), 64'(fs_cnt));
        check("idle_sdata_high", 64'(hi_cnt), 64'(0));
        @(posedge clk); #1;
        enable = 1'b0;
        step(3);

        // Directed vectors: preload, enable, capture the first frame
        for (int v = 0; v < 4; v++) begin
            send_pair(vecs[v].l, vecs[v].r);
            enable = 1'b1;
            capture_frame(sd, lr, ur);
            enable = 1'b0;
            $display("[TB] vec %0d L=%06h R=%06h left_slot=%08h right_slot=%08h", v, vecs[v].l, vecs[v].r, sd[63:32], sd[31:0]);
            check($sformatf("vec%0d_left_slot", v), 64'(sd[63:32]), 64'(vecs[v].exp_ls));
            check($sformatf("vec%0d_right_slot", v), 64'(sd[31:0]), 64'(vecs[v].exp_rs));
            check($sformatf("vec%0d_lrclk", v), lr, 64'h0000_0000_FFFF_FFFF);
            check($sformatf("vec%0d_underrun", v), 64'(ur), 64'(0));
            step(3);
        end

        // s_valid held high across frames with three pairs
        enable = 1'b1;
        idx = 0; n = 0;
        s_left = p4_l[0]; s_right = p4_r[0]; s_valid = 1'b1;
        while (idx < 3 && n < 3000) begin
            rdy = s_ready;
            step(1); n++;
            if (rdy) begin
                $display("[TB] streamed pair %0d L=%06h R=%06h", idx, p4_l[idx], p4_r[idx]);
                check("s_ready_low_after_handshake", 64'(s_ready), 64'(0));
                idx++;
                if (idx < 3) begin s_left = p4_l[idx]; s_right = p4_r[idx]; end
            end
        end
        s_valid = 1'b0;
        check("streamed_pairs", 64'(idx), 64'(3));
        step(4 * FRAME_CYC);

        // Randomized traffic with occasional enable drops
        for (int k = 0; k < 30; k++) begin
            step(int'($urandom_range(0, 400)));
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                step(int'($urandom_range(1, 50)));
                enable = 1'b1;
            end
            send_pair(DW'($urandom), DW'($urandom));
        end
        step(3 * FRAME_CYC);

        // Abort mid-frame with a pending pair in the holding register
        send_pair(24'hFFFFFF, 24'hFFFFFF);
        n = 0;
        do begin wait_fs(); n++; end while (underrun && n < 4);
        check("abort_frame_loaded", 64'(underrun), 64'(0));
        @(posedge clk); #1;
        s_left = 24'h0F0F0F; s_right = 24'h3C3C3C; s_valid = 1'b1;
        step(1);
        s_valid = 1'b0;
        repeat (4 * 40 - 2) @(posedge clk);
        #1;
        check("sdata_at_bit40", 64'({lrclk, sdata_out}), 64'(2'b11));
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        $display("[TB] enable dropped at bit 40: bclk=%0b lrclk=%0b sdata=%0b s_ready=%0b", bclk, lrclk, sdata_out, s_ready);
        check("abort_outputs_zero", 64'({bclk, lrclk, sdata_out}), 64'(0));
        check("abort_hold_kept", 64'(s_ready), 64'(0));
        step(20);
        check("abort_hold_still_kept", 64'(s_ready), 64'(0));
        enable = 1'b1;
        capture_frame(sd, lr, ur);
        $display("[TB] re-enable frame sdata=%016h underrun=%0b", sd, ur);
        check("reenable_pending_pair", sd, {slot_word(24'h0F0F0F), slot_word(24'h3C3C3C)});
        check("reenable_underrun", 64'(ur), 64'(0));

`ifdef I2S_RX_EN
        // Loopback capture
        enable = 1'b0;
        step(3);
        send_pair(24'h123456, 24'hABCDEF);
        enable = 1'b1;
        wait_fs();
        check("m_valid_first_frame", 64'(m_valid), 64'(0));
        wait_fs();
        $display("[TB] capture m_valid=%0b m_left=%06h m_right=%06h", m_valid, m_left, m_right);
        check("m_valid_second_frame", 64'(m_valid), 64'(1));
        check("m_left_loopback", 64'(m_left), 64'(24'h123456));
        check("m_right_loopback", 64'(m_right), 64'(24'hABCDEF));
        @(posedge clk); #1;
`endif

        enable = 1'b0;
        step(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
